// File: rtl/mycpu_pkg.sv
// Shared types and constants for the 3-way word distributor.
package mycpu_pkg;

  localparam int unsigned CLK_PERIOD   = 10;
  localparam int unsigned DEMUX_DATA_W = 16;
  localparam int unsigned DEMUX_NUM_CH = 3;
  localparam int unsigned DROP_CNT_W   = 8;

  typedef logic [1:0] demux_sel_t;

  localparam demux_sel_t DEMUX_SEL_Q0      = 2'd0;
  localparam demux_sel_t DEMUX_SEL_Q1      = 2'd1;
  localparam demux_sel_t DEMUX_SEL_Q2      = 2'd2;
  localparam demux_sel_t DEMUX_SEL_ILLEGAL = 2'd3;

  // True when the select addresses a real consumer channel.
  function automatic logic sel_is_legal(demux_sel_t sel);
    return sel != DEMUX_SEL_ILLEGAL;
  endfunction

endpackage

// File: rtl/demux_3x16_if.sv
// Producer and consumer handshake bundle for demux_3x16.
// Optional macro DEMUX_DROP_CNT_EN adds the drop_cnt_out counter signal.
interface demux_3x16_if
  import mycpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEMUX_DATA_W
);

  // Producer side
  logic              valid_in;
  logic              ready_out;
  demux_sel_t        sel_in;
  logic [DATA_W-1:0] d_in;

  // Consumer channels
  logic              q0_valid;
  logic              q0_ready;
  logic [DATA_W-1:0] q0_out;
  logic              q1_valid;
  logic              q1_ready;
  logic [DATA_W-1:0] q1_out;
  logic              q2_valid;
  logic              q2_ready;
  logic [DATA_W-1:0] q2_out;

  // Status
  logic              err_out;
`ifdef DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_out;
`endif

  // Producer and consumers drive the block
  modport master (
    output valid_in, sel_in, d_in, q0_ready, q1_ready, q2_ready,
    input  ready_out, q0_valid, q0_out, q1_valid, q1_out, q2_valid, q2_out,
`ifdef DEMUX_DROP_CNT_EN
    input  drop_cnt_out,
`endif
    input  err_out
  );

  // The distributor itself
  modport slave (
    input  valid_in, sel_in, d_in, q0_ready, q1_ready, q2_ready,
    output ready_out, q0_valid, q0_out, q1_valid, q1_out, q2_valid, q2_out,
`ifdef DEMUX_DROP_CNT_EN
    output drop_cnt_out,
`endif
    output err_out
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head word is presented from storage, zero when empty.
module sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head word straight from storage; forced to zero while empty
  always_comb begin
    dout = '0;
    if (!empty) dout = mem[rd_ptr];
  end

  // Pointers and occupancy; wrap is implicit since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; cleared on reset so no stale word survives a restart
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/demux_3x16.sv
// Registered 1-to-3 word distributor with an independent FIFO per consumer.
// Optional macro DEMUX_DROP_CNT_EN adds a saturating count of dropped words.
module demux_3x16
  import mycpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEMUX_DATA_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  demux_3x16_if.slave  bus
);

  logic [DEMUX_NUM_CH-1:0] full;
  logic [DEMUX_NUM_CH-1:0] empty;
  logic [DEMUX_NUM_CH-1:0] push;
  logic                    ready_c;
  logic                    accept;
  logic                    drop;
  logic                    err_q;

  // Ready depends only on the addressed FIFO; illegal selects are always taken
  always_comb begin
    ready_c = 1'b1;
    case (bus.sel_in)
      DEMUX_SEL_Q0: ready_c = !full[0];
      DEMUX_SEL_Q1: ready_c = !full[1];
      DEMUX_SEL_Q2: ready_c = !full[2];
      default:      ready_c = 1'b1;
    endcase
  end

  assign bus.ready_out = ready_c;
  assign accept        = bus.valid_in && ready_c;

  // Steer an accepted word to its channel or flag it as dropped
  always_comb begin
    push = '0;
    drop = 1'b0;
    if (accept) begin
      case (bus.sel_in)
        DEMUX_SEL_Q0: push[0] = 1'b1;
        DEMUX_SEL_Q1: push[1] = 1'b1;
        DEMUX_SEL_Q2: push[2] = 1'b1;
        default:      drop    = 1'b1;
      endcase
    end
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_q0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[0]),
    .din   (bus.d_in),
    .full  (full[0]),
    .pop   (bus.q0_ready),
    .dout  (bus.q0_out),
    .empty (empty[0])
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_q1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[1]),
    .din   (bus.d_in),
    .full  (full[1]),
    .pop   (bus.q1_ready),
    .dout  (bus.q1_out),
    .empty (empty[1])
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_q2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[2]),
    .din   (bus.d_in),
    .full  (full[2]),
    .pop   (bus.q2_ready),
    .dout  (bus.q2_out),
    .empty (empty[2])
  );

  assign bus.q0_valid = !empty[0];
  assign bus.q1_valid = !empty[1];
  assign bus.q2_valid = !empty[2];

  // Sticky illegal-select flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (drop) err_q <= 1'b1;
  end

  assign bus.err_out = err_q;

`ifdef DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Saturating count of dropped words
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign bus.drop_cnt_out = drop_cnt_q;
`endif

  // A stalled producer must hold its word until it is taken
  producer_hold_a : assert property (
    @(posedge clk) disable iff (rst)
    (bus.valid_in && !bus.ready_out) |=>
      (bus.valid_in && $stable(bus.sel_in) && $stable(bus.d_in))
  );

endmodule

// File: tb/tb_demux_3x16.sv
// Directed table plus random stream bench for demux_3x16 with a queue-based reference.
module tb_demux_3x16;
  import mycpu_pkg::*;

  localparam int unsigned DW     = 16;
  localparam int unsigned DEPTH  = 2;
  localparam int          NWORDS = 1000;
  localparam int          NTBL   = 28;

  logic clk;
  logic rst;

  demux_3x16_if #(.DATA_W(DW)) bus ();

  demux_3x16 #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK_PERIOD / 2) clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  sel;
    logic [15:0] d;
    logic [2:0]  rdy;
    logic        exp_ready;
    logic [2:0]  exp_valid;
    logic [15:0] exp_q0;
    logic [15:0] exp_q1;
    logic [15:0] exp_q2;
    logic        exp_err;
  } vec_t;

  vec_t tbl [NTBL];

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus status
  logic [15:0] m0 [$];
  logic [15:0] m1 [$];
  logic [15:0] m2 [$];
  logic        m_err;
  logic [7:0]  m_drop;
  int          m_push;
  int          m_pop;

  function automatic int msize(int ch);
    case (ch)
      0:       return m0.size();
      1:       return m1.size();
      default: return m2.size();
    endcase
  endfunction

  function automatic logic [15:0] mfront(int ch);
    if (msize(ch) == 0) return 16'h0000;
    case (ch)
      0:       return m0[0];
      1:       return m1[0];
      default: return m2[0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setv(input int i, input logic r, input logic v, input logic [1:0] s,
                      input logic [15:0] d, input logic [2:0] rdy, input logic er,
                      input logic [2:0] ev, input logic [15:0] e0, input logic [15:0] e1,
                      input logic [15:0] e2, input logic ee);
    tbl[i].rst = r;  tbl[i].valid = v; tbl[i].sel = s; tbl[i].d = d; tbl[i].rdy = rdy;
    tbl[i].exp_ready = er; tbl[i].exp_valid = ev;
    tbl[i].exp_q0 = e0; tbl[i].exp_q1 = e1; tbl[i].exp_q2 = e2; tbl[i].exp_err = ee;
  endtask

  // Drive one cycle, compare before the edge, then advance the model
  task automatic cycle(input vec_t t, input bit use_exp, input int idx, output logic acc);
    logic exp_rdy;
    rst          = t.rst;
    bus.valid_in = t.valid;
    bus.sel_in   = t.sel;
    bus.d_in     = t.d;
    bus.q0_ready = t.rdy[0];
    bus.q1_ready = t.rdy[1];
    bus.q2_ready = t.rdy[2];
    #2;
    exp_rdy = (t.sel == 2'd3) ? 1'b1 : (msize(int'(t.sel)) < int'(DEPTH));
    chk("ready_out", 32'(bus.ready_out), 32'(exp_rdy));
    chk("q0_valid", 32'(bus.q0_valid), 32'(msize(0) != 0));
    chk("q1_valid", 32'(bus.q1_valid), 32'(msize(1) != 0));
    chk("q2_valid", 32'(bus.q2_valid), 32'(msize(2) != 0));
    chk("q0_out", 32'(bus.q0_out), 32'(mfront(0)));
    chk("q1_out", 32'(bus.q1_out), 32'(mfront(1)));
    chk("q2_out", 32'(bus.q2_out), 32'(mfront(2)));
    chk("err_out", 32'(bus.err_out), 32'(m_err));
`ifdef DEMUX_DROP_CNT_EN
    chk("drop_cnt_out", 32'(bus.drop_cnt_out), 32'(m_drop));
`endif
    if (use_exp) begin
      chk($sformatf("v%0d_ready", idx), 32'(bus.ready_out), 32'(t.exp_ready));
      chk($sformatf("v%0d_valid", idx), 32'({bus.q2_valid, bus.q1_valid, bus.q0_valid}),
          32'(t.exp_valid));
      chk($sformatf("v%0d_q0", idx), 32'(bus.q0_out), 32'(t.exp_q0));
      chk($sformatf("v%0d_q1", idx), 32'(bus.q1_out), 32'(t.exp_q1));
      chk($sformatf("v%0d_q2", idx), 32'(bus.q2_out), 32'(t.exp_q2));
      chk($sformatf("v%0d_err", idx), 32'(bus.err_out), 32'(t.exp_err));
    end
    acc = t.valid && exp_rdy;
    @(posedge clk);
    #1;
    if (t.rst) begin
      m0.delete(); m1.delete(); m2.delete();
      m_err  = 1'b0;
      m_drop = 8'h00;
    end else begin
      if (t.rdy[0] && m0.size() != 0) begin void'(m0.pop_front()); m_pop++; end
      if (t.rdy[1] && m1.size() != 0) begin void'(m1.pop_front()); m_pop++; end
      if (t.rdy[2] && m2.size() != 0) begin void'(m2.pop_front()); m_pop++; end
      if (acc) begin
        case (t.sel)
          2'd0:    begin m0.push_back(t.d); m_push++; end
          2'd1:    begin m1.push_back(t.d); m_push++; end
          2'd2:    begin m2.push_back(t.d); m_push++; end
          default: begin
            m_err = 1'b1;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
          end
        endcase
      end
    end
  endtask

  initial begin
    vec_t  v;
    logic  acc;
    bit    blocked;
    int    cyc;
    int    words;

    // Directed vectors: rst valid sel d rdy | ready valid q0 q1 q2 err
    // single word through q0
    setv( 0, 0, 1, 0, 16'h1234, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);
    setv( 1, 0, 0, 0, 16'h0000, 3'b001, 1, 3'b001, 16'h1234, 16'h0000, 16'h0000, 0);
    setv( 2, 0, 0, 0, 16'h0000, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);
    // stalled q1 fills, q2 still accepts, then drain back to back
    setv( 3, 0, 1, 1, 16'hA001, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);
    setv( 4, 0, 1, 1, 16'hA002, 3'b000, 1, 3'b010, 16'h0000, 16'hA001, 16'h0000, 0);
    setv( 5, 0, 0, 1, 16'h0000, 3'b000, 0, 3'b010, 16'h0000, 16'hA001, 16'h0000, 0);
    setv( 6, 0, 1, 2, 16'hB000, 3'b000, 1, 3'b010, 16'h0000, 16'hA001, 16'h0000, 0);
    setv( 7, 0, 0, 1, 16'h0000, 3'b010, 0, 3'b110, 16'h0000, 16'hA001, 16'hB000, 0);
    setv( 8, 0, 0, 1, 16'h0000, 3'b010, 1, 3'b110, 16'h0000, 16'hA002, 16'hB000, 0);
    setv( 9, 0, 0, 0, 16'h0000, 3'b100, 1, 3'b100, 16'h0000, 16'h0000, 16'hB000, 0);
    setv(10, 0, 0, 0, 16'h0000, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);
    // illegal select dropped, sticky error
    setv(11, 0, 1, 3, 16'hDEAD, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);
    setv(12, 0, 0, 0, 16'h0000, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1);
    setv(13, 0, 1, 0, 16'h0001, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1);
    setv(14, 0, 1, 0, 16'h0002, 3'b000, 1, 3'b001, 16'h0001, 16'h0000, 16'h0000, 1);
    // full q0: push blocked while head pops, then accepted, order 1,2,3
    setv(15, 0, 1, 0, 16'h0003, 3'b001, 0, 3'b001, 16'h0001, 16'h0000, 16'h0000, 1);
    setv(16, 0, 1, 0, 16'h0003, 3'b000, 1, 3'b001, 16'h0002, 16'h0000, 16'h0000, 1);
    setv(17, 0, 0, 0, 16'h0000, 3'b001, 0, 3'b001, 16'h0002, 16'h0000, 16'h0000, 1);
    setv(18, 0, 0, 0, 16'h0000, 3'b001, 1, 3'b001, 16'h0003, 16'h0000, 16'h0000, 1);
    setv(19, 0, 0, 0, 16'h0000, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1);
    // reset with two words in q0 and one in q2
    setv(20, 0, 1, 0, 16'h0011, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1);
    setv(21, 0, 1, 0, 16'h0012, 3'b000, 1, 3'b001, 16'h0011, 16'h0000, 16'h0000, 1);
    setv(22, 0, 1, 2, 16'h0021, 3'b000, 1, 3'b001, 16'h0011, 16'h0000, 16'h0000, 1);
    setv(23, 1, 0, 0, 16'h0000, 3'b000, 0, 3'b101, 16'h0011, 16'h0000, 16'h0021, 1);
    setv(24, 0, 0, 0, 16'h0000, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);
    setv(25, 0, 0, 1, 16'h0000, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);
    setv(26, 0, 0, 2, 16'h0000, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);
    setv(27, 0, 0, 3, 16'h0000, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0);

    // Initial reset
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.sel_in = 2'd0; bus.d_in = 16'h0000;
    bus.q0_ready = 1'b0; bus.q1_ready = 1'b0; bus.q2_ready = 1'b0;
    m_err = 1'b0; m_drop = 8'h00; m_push = 0; m_pop = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NTBL; i++) cycle(tbl[i], 1'b1, i, acc);

    // Random stream on legal selects with random consumer readiness
    m_push  = 0;
    m_pop   = 0;
    words   = 0;
    cyc     = 0;
    blocked = 1'b0;
    v.rst = 1'b0; v.valid = 1'b0; v.sel = 2'd0; v.d = 16'h0000; v.rdy = 3'b000;
    v.exp_ready = 1'b0; v.exp_valid = 3'b000; v.exp_q0 = 16'h0; v.exp_q1 = 16'h0;
    v.exp_q2 = 16'h0; v.exp_err = 1'b0;
    while (words < NWORDS && cyc < 20000) begin
      if (!blocked) begin
        v.valid = ($urandom_range(0, 3) != 0);
        v.sel   = 2'($urandom_range(0, 2));
        v.d     = 16'($urandom);
      end
      v.rdy = 3'($urandom_range(0, 7));
      cycle(v, 1'b0, 0, acc);
      blocked = v.valid && !acc;
      if (acc) words++;
      cyc++;
    end
    chk("stream_accepted", 32'(words), 32'(NWORDS));

    // Drain everything still buffered
    v.valid = 1'b0;
    v.rdy   = 3'b111;
    cyc     = 0;
    while ((m0.size() + m1.size() + m2.size()) != 0 && cyc < 20) begin
      cycle(v, 1'b0, 0, acc);
      cyc++;
    end
    cycle(v, 1'b0, 0, acc);
    chk("drain_empty", 32'({bus.q2_valid, bus.q1_valid, bus.q0_valid}), 32'(0));
    chk("no_loss", 32'(m_pop), 32'(NWORDS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
